// File: rtl/space_inv_pkg.sv
// Shared keycodes, player FSM state encoding and screen coordinate type for
// the Space Invaders datapath.
package space_inv_pkg;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    typedef enum logic [1:0] {
        ALIVE,
        RESPAWN,
        DEAD
    } player_state_t;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/key_decode.sv
// Combinational USB keyboard report decoder: flags A (left), D (right) and
// Space (fire) if present in any keycode slot. Also used by the menu FSM.
module key_decode
    import space_inv_pkg::*;
#(
    parameter int NUM_KEYS = 6
) (
    input  logic [8*NUM_KEYS-1:0] keycodes,
    output logic                  left,
    output logic                  right,
    output logic                  fire
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        left  = 1'b0;
        right = 1'b0;
        fire  = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keycodes[8*i +: 8] == KEY_A)     left  = 1'b1;
            if (keycodes[8*i +: 8] == KEY_D)     right = 1'b1;
            if (keycodes[8*i +: 8] == KEY_SPACE) fire  = 1'b1;
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Player cannon controller: clamped motion, rate-limited firing, lives and a
// respawn/game-over FSM, updated once per frame. Optional macro
// PLAYER_AUTOFIRE_EN makes firing level-triggered (hold Space to autofire).
module player_ctrl
    import space_inv_pkg::*;
#(
    parameter int NUM_KEYS       = 6,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 639,
    parameter int X_CENTER       = 320,
    parameter int STEP           = 2,
    parameter int SIZE           = 8,
    parameter int COOLDOWN       = 15,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    input  logic                  hit,
    input  logic                  bullet_active,
    output coord_t                player_X,
    output coord_t                player_s,
    output logic                  shoot_bullet,
    output logic [2:0]            lives,
    output logic                  respawning,
    output logic                  game_over
);

    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int RS_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

    localparam logic [CD_W-1:0]   CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [RS_W-1:0]   RS_LOAD = RS_W'(RESPAWN_FRAMES - 1);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] X_LO   = 11'(X_MIN + SIZE);
    localparam logic signed [10:0] X_HI   = 11'(X_MAX - SIZE);

    player_state_t    r_state;
    coord_t           r_x;
    logic             r_shoot;
    logic [2:0]       r_lives;
    logic [CD_W-1:0]  r_cd;
    logic [RS_W-1:0]  r_resp_cnt;
    logic             r_fire_prev;

    logic             w_left;
    logic             w_right;
    logic             w_fire;
    logic             w_fire_trig;
    logic             w_shot;
    logic signed [10:0] w_x_ext;
    logic signed [10:0] w_x_next;

    key_decode #(.NUM_KEYS(NUM_KEYS)) u_key_decode (
        .keycodes (keycodes),
        .left     (w_left),
        .right    (w_right),
        .fire     (w_fire)
    );

`ifdef PLAYER_AUTOFIRE_EN
    assign w_fire_trig = w_fire;
`else
    assign w_fire_trig = w_fire & ~r_fire_prev;
`endif

    assign w_shot = (r_state == ALIVE) && w_fire_trig && (r_cd == '0)
                    && !bullet_active && !hit;

    // Signed 11-bit arithmetic so a step past either edge clamps instead of wrapping.
    assign w_x_ext = signed'({1'b0, r_x});

    always_comb begin
        w_x_next = w_x_ext;
        if (w_left && !w_right) begin
            w_x_next = w_x_ext - STEP_S;
            if (w_x_next < X_LO) w_x_next = X_LO;
        end else if (w_right && !w_left) begin
            w_x_next = w_x_ext + STEP_S;
            if (w_x_next > X_HI) w_x_next = X_HI;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ALIVE;
            r_x         <= coord_t'(X_CENTER);
            r_shoot     <= 1'b0;
            r_lives     <= 3'(LIVES);
            r_cd        <= '0;
            r_resp_cnt  <= '0;
            r_fire_prev <= 1'b0;
        end else begin
            r_fire_prev <= w_fire;
            r_shoot     <= w_shot;

            if (w_shot)
                r_cd <= CD_LOAD;
            else if (r_cd != '0)
                r_cd <= r_cd - CD_W'(1);

            case (r_state)
                ALIVE: begin
                    if (hit) begin
                        if (r_lives > 3'd1) begin
                            r_lives    <= r_lives - 3'd1;
                            r_state    <= RESPAWN;
                            r_x        <= coord_t'(X_CENTER);
                            r_resp_cnt <= RS_LOAD;
                        end else begin
                            r_lives <= 3'd0;
                            r_state <= DEAD;
                        end
                    end else begin
                        r_x <= w_x_next[9:0];
                    end
                end
                RESPAWN: begin
                    if (r_resp_cnt == '0)
                        r_state <= ALIVE;
                    else
                        r_resp_cnt <= r_resp_cnt - RS_W'(1);
                end
                DEAD: begin
                    // Terminal until Reset.
                end
                default: r_state <= ALIVE;
            endcase
        end
    end

    assign player_X     = r_x;
    assign player_s     = coord_t'(SIZE);
    assign shoot_bullet = r_shoot;
    assign lives        = r_lives;
    assign respawning   = (r_state == RESPAWN);
    assign game_over    = (r_state == DEAD);

endmodule

// File: tb/tb_player_ctrl.sv
// Directed self-checking bench for player_ctrl with default parameters.
// Honours PLAYER_AUTOFIRE_EN when the design is built with it.
module tb_player_ctrl;

    logic        Reset;
    logic        frame_clk;
    logic [47:0] keycodes;
    logic        hit;
    logic        bullet_active;
    logic [9:0]  player_X;
    logic [9:0]  player_s;
    logic        shoot_bullet;
    logic [2:0]  lives;
    logic        respawning;
    logic        game_over;

    int checks   = 0;
    int failures = 0;

    player_ctrl dut (
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .keycodes      (keycodes),
        .hit           (hit),
        .bullet_active (bullet_active),
        .player_X      (player_X),
        .player_s      (player_s),
        .shoot_bullet  (shoot_bullet),
        .lives         (lives),
        .respawning    (respawning),
        .game_over     (game_over)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // One frame: inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // A in slot 0, D in slot 3, Space in slot 5.
    task automatic set_keys(input logic a, input logic d, input logic sp);
        keycodes = '0;
        if (a)  keycodes[7:0]   = 8'h04;
        if (d)  keycodes[31:24] = 8'h07;
        if (sp) keycodes[47:40] = 8'h2C;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        hit = 1'b0;
        bullet_active = 1'b0;
        set_keys(0, 0, 0);
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (player_X !== 10'd320) begin failures++; $display("FAIL reset_x got=%0d exp=320", player_X); end
        checks++;
        if (player_s !== 10'd8) begin failures++; $display("FAIL reset_size got=%0d exp=8", player_s); end
        checks++;
        if (lives !== 3'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        checks++;
        if ({shoot_bullet, respawning, game_over} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {shoot_bullet, respawning, game_over});
        end
    endtask

    task automatic test_move_right();
        int exp_x;
        do_reset();
        exp_x = 320;
        set_keys(0, 1, 0);
        for (int i = 0; i < 200; i++) begin
            tick();
            exp_x = (exp_x + 2 > 631) ? 631 : exp_x + 2;
            checks++;
            if (player_X !== 10'(exp_x)) begin
                failures++; $display("FAIL move_right frame=%0d got=%0d exp=%0d", i, player_X, exp_x);
            end
        end
    endtask

    task automatic test_move_left();
        do_reset();
        set_keys(1, 0, 0);
        for (int i = 0; i < 400; i++) begin
            tick();
            if (i == 0 || i == 155 || i == 156 || i == 399) begin
                checks++;
                if (player_X !== ((i == 0) ? 10'd318 : 10'd8)) begin
                    failures++; $display("FAIL move_left frame=%0d got=%0d", i, player_X);
                end
            end
        end
        set_keys(1, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (player_X !== 10'd8) begin failures++; $display("FAIL both_keys_at_min got=%0d exp=8", player_X); end
        set_keys(0, 1, 0);
        for (int i = 0; i < 10; i++) tick();
        set_keys(1, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (player_X !== 10'd28) begin failures++; $display("FAIL both_keys_mid got=%0d exp=28", player_X); end
    endtask

    task automatic test_fire();
        logic exp_s;
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        set_keys(0, 0, 1);
        tick();
        checks++;
        if (shoot_bullet !== 1'b1) begin failures++; $display("FAIL fire_first got=%b exp=1", shoot_bullet); end
        for (int i = 1; i <= 40; i++) begin
            tick();
`ifdef PLAYER_AUTOFIRE_EN
            exp_s = (i % 16 == 0);
`else
            exp_s = 1'b0;
`endif
            checks++;
            if (shoot_bullet !== exp_s) begin
                failures++; $display("FAIL fire_hold frame=%0d got=%b exp=%b", i, shoot_bullet, exp_s);
            end
        end
        set_keys(0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
    endtask

    task automatic test_fire_blocked();
        set_keys(0, 0, 1);
        tick();
        checks++;
        if (shoot_bullet !== 1'b1) begin failures++; $display("FAIL blk_first got=%b exp=1", shoot_bullet); end
        set_keys(0, 0, 0);
        tick();
        checks++;
        if (shoot_bullet !== 1'b0) begin failures++; $display("FAIL blk_pulse_width got=%b exp=0", shoot_bullet); end
        for (int i = 0; i < 9; i++) tick();
        // Cooldown is now 5.
        set_keys(0, 0, 1);
        tick();
        checks++;
        if (shoot_bullet !== 1'b0) begin failures++; $display("FAIL blk_cooldown got=%b exp=0", shoot_bullet); end
        set_keys(0, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        bullet_active = 1'b1;
        set_keys(0, 0, 1);
        tick();
        checks++;
        if (shoot_bullet !== 1'b0) begin failures++; $display("FAIL blk_bullet_active got=%b exp=0", shoot_bullet); end
        bullet_active = 1'b0;
        set_keys(0, 0, 0);
        tick();
        set_keys(0, 0, 1);
        tick();
        checks++;
        if (shoot_bullet !== 1'b1) begin failures++; $display("FAIL blk_fresh_press got=%b exp=1", shoot_bullet); end
        set_keys(0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
    endtask

    task automatic test_hit_respawn();
        do_reset();
        set_keys(0, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (player_X !== 10'd330) begin failures++; $display("FAIL pre_hit_x got=%0d exp=330", player_X); end
        hit = 1'b1;
        set_keys(0, 1, 1);
        tick();
        hit = 1'b0;
        checks++;
        if ({player_X, lives, respawning, shoot_bullet} !== {10'd320, 3'd2, 1'b1, 1'b0}) begin
            failures++; $display("FAIL hit_entry x=%0d lives=%0d resp=%b shoot=%b exp x=320 lives=2 resp=1 shoot=0",
                                 player_X, lives, respawning, shoot_bullet);
        end
        for (int i = 1; i < 60; i++) begin
            set_keys(i % 2 == 0, 1, i % 2 == 1);
            hit = (i % 7 == 0);
            tick();
            checks++;
            if ({player_X, lives, respawning, shoot_bullet} !== {10'd320, 3'd2, 1'b1, 1'b0}) begin
                failures++; $display("FAIL respawn frame=%0d x=%0d lives=%0d resp=%b shoot=%b",
                                     i, player_X, lives, respawning, shoot_bullet);
            end
        end
        hit = 1'b0;
        set_keys(0, 1, 0);
        tick();
        checks++;
        if ({player_X, respawning} !== {10'd320, 1'b0}) begin
            failures++; $display("FAIL respawn_exit x=%0d resp=%b exp x=320 resp=0", player_X, respawning);
        end
        tick();
        checks++;
        if (player_X !== 10'd322) begin failures++; $display("FAIL alive_again_x got=%0d exp=322", player_X); end
        set_keys(0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_game_over();
        // Continues from lives=2, player_X=322.
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks++;
        if ({lives, respawning} !== {3'd1, 1'b1}) begin
            failures++; $display("FAIL second_hit lives=%0d resp=%b exp lives=1 resp=1", lives, respawning);
        end
        for (int i = 0; i < 60; i++) tick();
        checks++;
        if (respawning !== 1'b0) begin failures++; $display("FAIL second_respawn_exit got=%b exp=0", respawning); end
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks++;
        if ({lives, game_over, respawning} !== {3'd0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL dead_entry lives=%0d go=%b resp=%b exp 0 1 0", lives, game_over, respawning);
        end
        for (int i = 0; i < 10; i++) begin
            set_keys(i % 2 == 1, 1, i % 2 == 0);
            hit = (i % 3 == 0);
            tick();
            checks++;
            if ({player_X, lives, game_over, shoot_bullet} !== {10'd320, 3'd0, 1'b1, 1'b0}) begin
                failures++; $display("FAIL dead_frozen frame=%0d x=%0d lives=%0d go=%b shoot=%b",
                                     i, player_X, lives, game_over, shoot_bullet);
            end
        end
        hit = 1'b0;
        Reset = 1'b1;
        #1;
        checks++;
        if ({player_X, lives, game_over} !== {10'd320, 3'd3, 1'b0}) begin
            failures++; $display("FAIL dead_reset x=%0d lives=%0d go=%b exp 320 3 0", player_X, lives, game_over);
        end
        set_keys(0, 0, 0);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_keys(0, 1, 0);
        for (int i = 0; i < 3; i++) tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        Reset = 1'b1;
        #1;
        checks++;
        if ({player_X, lives, respawning} !== {10'd320, 3'd3, 1'b0}) begin
            failures++; $display("FAIL reset_mid_respawn x=%0d lives=%0d resp=%b", player_X, lives, respawning);
        end
        set_keys(0, 0, 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        set_keys(0, 0, 1);
        tick();
        Reset = 1'b1;
        #1;
        checks++;
        if (shoot_bullet !== 1'b0) begin failures++; $display("FAIL reset_mid_shot got=%b exp=0", shoot_bullet); end
        set_keys(0, 0, 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        tick();
        set_keys(0, 0, 1);
        tick();
        checks++;
        if (shoot_bullet !== 1'b1) begin failures++; $display("FAIL reset_clears_cooldown got=%b exp=1", shoot_bullet); end
        set_keys(0, 0, 0);
    endtask

    initial begin
        Reset = 1'b1;
        hit = 1'b0;
        bullet_active = 1'b0;
        keycodes = '0;
        test_reset();
        test_move_right();
        test_move_left();
        test_fire();
        test_fire_blocked();
        test_hit_respawn();
        test_game_over();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
